baud_cfg_arb: RTL and testbench
===============================

BAUD_CFG_ARB -- requirements
Module: baud_cfg_arb

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter DIV0, 16'h028A, divisor for sel 0 (4800 baud at 50 MHz).
REQ-002 The block SHALL have parameter DIV1, 16'h0145, divisor for sel 1 (9600 baud).
REQ-003 The block SHALL have parameter DIV2, 16'h00A2, divisor for sel 2 (19200 baud).
REQ-004 The block SHALL have parameter DIV3, 16'h0050, divisor for sel 3 (38400 baud).
REQ-005 The block SHALL have parameter DEFAULT_SEL, 2'd1, the rate programmed automatically after reset.
REQ-006 The block SHALL have parameter TIMEOUT, 20'hFFFFF, the maximum number of SETTLE cycles.

Ports, one per line: name, direction, width, meaning.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state on its rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_req  in  1  1-cycle request to program the rate selected by cfg_sel.
- cfg_sel  in  2  rate select, sampled with cfg_req.
- host_req  in  1  host bus cycle request.
- host_ioaddr  in  2  host register address.
- host_data  in  8  host write data.
- baud_trmt_en  in  1  transmit-enable pulse from the baud generator.
- brg_ioaddr  out  2  address to the baud generator and SPART bus.
- brg_data  out  8  data to the baud generator and SPART bus.
- host_grant  out  1  the host cycle is driven this cycle.
- host_err  out  1  the host attempted a divisor address (2'b10/2'b11).
- cfg_busy  out  1  a configuration sequence is active.
- cfg_ack  out  1  1-cycle pulse: the new rate is confirmed.
- cfg_timeout  out  1  1-cycle pulse: settle was abandoned.
- cfg_valid  out  1  at least one configuration has completed since reset.
- cur_sel  out  2  the last confirmed rate select.

Function
REQ-008 The block SHALL implement the states IDLE, WR_LO, WR_HI and SETTLE.
REQ-009 IDLE SHALL go to WR_LO when cfg_req or pend is set; the latched select is cfg_sel when cfg_req is high, otherwise pend_sel.
REQ-010 WR_LO SHALL drive brg_ioaddr=2'b10 and brg_data=DIVn[7:0] for exactly 1 cycle, then go to WR_HI.
REQ-011 WR_HI SHALL drive brg_ioaddr=2'b11 and brg_data=DIVn[15:8] for exactly 1 cycle, then go to SETTLE; WR_LO and WR_HI SHALL always be back-to-back.
REQ-012 SETTLE SHALL count cycles from 0 (20-bit counter), with the following exits:
- baud_trmt_en=1: go to IDLE; next cycle cfg_ack=1, cur_sel=latched select, cfg_valid=1.
- counter==TIMEOUT without baud_trmt_en: go to IDLE; next cycle cfg_timeout=1; cur_sel and cfg_valid unchanged.
- baud_trmt_en and timeout in the same cycle: ack wins.
REQ-013 cfg_req at cycle N in IDLE SHALL produce WR_LO at N+1, WR_HI at N+2 and SETTLE from N+3.
REQ-014 cfg_busy SHALL be 1 in WR_LO, WR_HI and SETTLE, and 0 in IDLE.
REQ-015 A cfg_req while cfg_busy=1 SHALL set pend=1 and pend_sel=cfg_sel; a later request overwrites pend_sel (newest wins); pend clears when its sequence starts.
REQ-016 A pending request SHALL start in the cycle after return to IDLE, at the same time as that cfg_ack or cfg_timeout pulse.
REQ-017 Arbitration SHALL be fixed priority with configuration first:
- host_grant = host_req & IDLE & !cfg_req & !pend & !host_ioaddr[1] (combinational).
- When granted, brg_ioaddr=host_ioaddr and brg_data=host_data in the same cycle.
REQ-018 host_err SHALL equal host_req & IDLE & host_ioaddr[1] (combinational); the host SHALL never reach ioaddr 2'b10/2'b11.
REQ-019 When the bus is neither granted nor in WR_LO/WR_HI, the block SHALL park it at brg_ioaddr=2'b01 and brg_data=8'h00.
REQ-020 A host stalled by configuration SHALL hold host_req; no host cycle is queued.
REQ-021 Divisor bytes SHALL be taken from parameters only; there is no arithmetic on the divisor.

Reset
REQ-022 With rst=1 at an edge, the block SHALL set: state=IDLE, cfg_busy=0, cfg_ack=0, cfg_timeout=0, cfg_valid=0, cur_sel=DEFAULT_SEL, settle counter=0.
REQ-023 Reset SHALL set pend=1 and pend_sel=DEFAULT_SEL, so the first cycle after reset starts a boot configuration.
REQ-024 Reset SHALL override every state, including mid-WR_LO, WR_HI or SETTLE; a partial divisor write is then redone by the boot sequence.

Verification
REQ-025 The bench SHALL cover each scenario below.
- Release rst -> WR_LO with 10/8'h45, then WR_HI with 11/8'h01, then SETTLE; baud_trmt_en pulse -> cfg_ack next cycle, cfg_valid=1, cur_sel=1.
- cfg_req, cfg_sel=3 in IDLE at N -> bus 10/8'h50 at N+1 and 11/8'h00 at N+2; cfg_busy=1 from N+1.
- cfg_req sel=0 then sel=2 while busy -> after ack, exactly one sequence with 10/8'hA2 and 11/8'h00.
- host_req ioaddr=00, data=8'h5A, concurrent with cfg_req -> host_grant=0, config runs, grant in the first idle cycle with nothing pending.
- host_req ioaddr=2'b11 -> host_err=1, host_grant=0, bus parked at 01/8'h00.
- Timeout with TIMEOUT=20'd15 and baud_trmt_en held 0 -> cfg_timeout after 16 SETTLE cycles; cur_sel unchanged.
- rst during WR_HI -> outputs at reset values next cycle, then boot sequence for DEFAULT_SEL.

Source files
------------

// File: rtl/baud_cfg_arb.sv
// Baud-rate configuration sequencer sharing the baud-generator/SPART bus with a host port; writes DIVn low/high back-to-back.
// Latency: cfg_req -> WR_LO next cycle; host grant is same-cycle. Backpressure: a stalled host must hold host_req, config requests made while busy collapse to one pending.
module baud_cfg_arb #(
    parameter logic [15:0] DIV0        = 16'h028A,
    parameter logic [15:0] DIV1        = 16'h0145,
    parameter logic [15:0] DIV2        = 16'h00A2,
    parameter logic [15:0] DIV3        = 16'h0050,
    parameter logic [1:0]  DEFAULT_SEL = 2'd1,
    parameter logic [19:0] TIMEOUT     = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_req,
    input  logic [1:0] cfg_sel,
    input  logic       host_req,
    input  logic [1:0] host_ioaddr,
    input  logic [7:0] host_data,
    input  logic       baud_trmt_en,
    output logic [1:0] brg_ioaddr,
    output logic [7:0] brg_data,
    output logic       host_grant,
    output logic       host_err,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_timeout,
    output logic       cfg_valid,
    output logic [1:0] cur_sel
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, SETTLE} state_t;

    state_t      r_state;
    logic        r_pend;
    logic [1:0]  r_pend_sel;
    logic [1:0]  r_sel;
    logic [1:0]  r_cur_sel;
    logic [19:0] r_cnt;
    logic        r_ack;
    logic        r_tmo;
    logic        r_valid;

    logic        w_idle;
    logic        w_grant;
    logic [15:0] w_div;

    assign w_idle = (r_state == IDLE);

    always_comb begin
        case (r_sel)
            2'd0:    w_div = DIV0;
            2'd1:    w_div = DIV1;
            2'd2:    w_div = DIV2;
            default: w_div = DIV3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pend     <= 1'b1;
            r_pend_sel <= DEFAULT_SEL;
            r_sel      <= DEFAULT_SEL;
            r_cur_sel  <= DEFAULT_SEL;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_tmo      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_tmo <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A fresh request supersedes whatever was pending.
                    if (cfg_req || r_pend) begin
                        r_state <= WR_LO;
                        r_sel   <= cfg_req ? cfg_sel : r_pend_sel;
                        r_pend  <= 1'b0;
                    end
                end
                WR_LO: r_state <= WR_HI;
                WR_HI: begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                end
                SETTLE: begin
                    if (baud_trmt_en) begin
                        r_state   <= IDLE;
                        r_ack     <= 1'b1;
                        r_cur_sel <= r_sel;
                        r_valid   <= 1'b1;
                    end else if (r_cnt == TIMEOUT) begin
                        r_state <= IDLE;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (cfg_req && !w_idle) begin
                r_pend     <= 1'b1;
                r_pend_sel <= cfg_sel;
            end
        end
    end

    // Configuration always outranks the host; divisor addresses are never host-reachable.
    assign w_grant = host_req && w_idle && !cfg_req && !r_pend && !host_ioaddr[1];

    always_comb begin
        brg_ioaddr = 2'b01;
        brg_data   = 8'h00;
        if (r_state == WR_LO) begin
            brg_ioaddr = 2'b10;
            brg_data   = w_div[7:0];
        end else if (r_state == WR_HI) begin
            brg_ioaddr = 2'b11;
            brg_data   = w_div[15:8];
        end else if (w_grant) begin
            brg_ioaddr = host_ioaddr;
            brg_data   = host_data;
        end
    end

    assign host_grant  = w_grant;
    assign host_err    = host_req && w_idle && host_ioaddr[1];
    assign cfg_busy    = !w_idle;
    assign cfg_ack     = r_ack;
    assign cfg_timeout = r_tmo;
    assign cfg_valid   = r_valid;
    assign cur_sel     = r_cur_sel;

endmodule

// File: tb/tb_baud_cfg_arb.sv
// Bench for baud_cfg_arb: transaction-level reference model feeds an expected-event queue, an independent monitor checks the DUT.
module tb_baud_cfg_arb;

    localparam logic [19:0] TO = 20'd15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_req = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic       host_req = 1'b0;
    logic [1:0] host_ioaddr = 2'd0;
    logic [7:0] host_data = 8'h00;
    logic       baud_trmt_en = 1'b0;
    logic [1:0] brg_ioaddr;
    logic [7:0] brg_data;
    logic       host_grant, host_err, cfg_busy, cfg_ack, cfg_timeout, cfg_valid;
    logic [1:0] cur_sel;

    always #5 clk = ~clk;

    baud_cfg_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .host_req(host_req), .host_ioaddr(host_ioaddr), .host_data(host_data),
        .baud_trmt_en(baud_trmt_en), .brg_ioaddr(brg_ioaddr), .brg_data(brg_data),
        .host_grant(host_grant), .host_err(host_err), .cfg_busy(cfg_busy),
        .cfg_ack(cfg_ack), .cfg_timeout(cfg_timeout), .cfg_valid(cfg_valid),
        .cur_sel(cur_sel)
    );

    typedef struct {
        int         cyc;
        logic [1:0] addr;
        logic [7:0] data;
        logic       grant, err, busy, ack, tmo, valid;
        logic [1:0] cur;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a sequence is "cycle k since start"; k=0 low byte, k=1 high byte, k>=2 settling.
    bit         m_busy, m_pend, m_ack, m_tmo, m_valid;
    int         m_k;
    logic [1:0] m_sel, m_pend_sel, m_cur;

    function automatic logic [15:0] div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 16'h028A;
            2'd1:    return 16'h0145;
            2'd2:    return 16'h00A2;
            default: return 16'h0050;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_sel = 2'd1; m_pend = 1; m_pend_sel = 2'd1;
        m_ack = 0; m_tmo = 0; m_valid = 0; m_cur = 2'd1;
    endtask

    task automatic model_step();
        ev_t         e;
        logic [15:0] d;
        bit          wr;
        d       = div_of(m_sel);
        e.cyc   = cyc;
        e.busy  = m_busy;
        e.ack   = m_ack;
        e.tmo   = m_tmo;
        e.valid = m_valid;
        e.cur   = m_cur;
        e.grant = host_req && !m_busy && !cfg_req && !m_pend && !host_ioaddr[1];
        e.err   = host_req && !m_busy && host_ioaddr[1];
        wr      = m_busy && (m_k < 2);
        if (m_busy && m_k == 0) begin
            e.addr = 2'b10; e.data = d[7:0];
        end else if (m_busy && m_k == 1) begin
            e.addr = 2'b11; e.data = d[15:8];
        end else if (e.grant) begin
            e.addr = host_ioaddr; e.data = host_data;
        end else begin
            e.addr = 2'b01; e.data = 8'h00;
        end
        if (wr || e.grant || e.err || e.ack || e.tmo) exp_q.push_back(e);

        m_ack = 0;
        m_tmo = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (cfg_req || m_pend) begin
                m_busy = 1; m_k = 0;
                m_sel  = cfg_req ? cfg_sel : m_pend_sel;
                m_pend = 0;
            end
        end else begin
            if (cfg_req) begin
                m_pend = 1; m_pend_sel = cfg_sel;
            end
            if (m_k >= 2 && baud_trmt_en) begin
                m_busy = 0; m_ack = 1; m_cur = m_sel; m_valid = 1;
            end else if (m_k >= 2 && (m_k - 2) == int'(TO)) begin
                m_busy = 0; m_tmo = 1;
            end else begin
                m_k = m_k + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit present;
            present = host_grant | host_err | brg_ioaddr[1] | cfg_ack | cfg_timeout;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                $display("FAIL missed_event cyc=%0d: DUT presented nothing, required addr=%0d data=%02h grant=%0d err=%0d ack=%0d tmo=%0d",
                         exp_q[0].cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].grant, exp_q[0].err, exp_q[0].ack, exp_q[0].tmo);
                void'(exp_q.pop_front());
            end
            if (present) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    $display("FAIL unexpected_event cyc=%0d: actual addr=%0d data=%02h grant=%0d err=%0d ack=%0d tmo=%0d, required none",
                             cyc, brg_ioaddr, brg_data, host_grant, host_err, cfg_ack, cfg_timeout);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (brg_ioaddr == e.addr && brg_data == e.data && host_grant == e.grant &&
                        host_err == e.err && cfg_busy == e.busy && cfg_ack == e.ack &&
                        cfg_timeout == e.tmo && cfg_valid == e.valid && cur_sel == e.cur) begin
                        n_pass++;
                    end else begin
                        $display("FAIL event cyc=%0d actual(addr=%0d data=%02h gnt=%0d err=%0d busy=%0d ack=%0d tmo=%0d vld=%0d cur=%0d) required(addr=%0d data=%02h gnt=%0d err=%0d busy=%0d ack=%0d tmo=%0d vld=%0d cur=%0d)",
                                 cyc, brg_ioaddr, brg_data, host_grant, host_err, cfg_busy, cfg_ack, cfg_timeout, cfg_valid, cur_sel,
                                 e.addr, e.data, e.grant, e.err, e.busy, e.ack, e.tmo, e.valid, e.cur);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(cfg_busy), 0);
        chk({tag, "_ack"}, int'(cfg_ack), 0);
        chk({tag, "_timeout"}, int'(cfg_timeout), 0);
        chk({tag, "_valid"}, int'(cfg_valid), 0);
        chk({tag, "_cur_sel"}, int'(cur_sel), 1);
        chk({tag, "_bus_addr"}, int'(brg_ioaddr), 1);
        chk({tag, "_bus_data"}, int'(brg_data), 0);
    endtask

    task automatic drv(input bit r, input bit cr, input logic [1:0] cs, input bit hr,
                       input logic [1:0] ha, input logic [7:0] hd, input bit te);
        rst = r; cfg_req = cr; cfg_sel = cs; host_req = hr;
        host_ioaddr = ha; host_data = hd; baud_trmt_en = te;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;
        chk_reset_outputs("reset");
        drv(1, 0, 2'd0, 0, 2'd0, 8'h00, 0);

        // Boot sequence for DEFAULT_SEL, confirmed by a transmit-enable pulse.
        quiet(7);
        drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 1);
        quiet(3);

        // Directed rate 3 request.
        drv(0, 1, 2'd3, 0, 2'd0, 8'h00, 0);
        chk("busy_after_req", int'(cfg_busy), 1);
        quiet(6);
        drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 1);
        quiet(2);

        // Two requests while busy: newest wins, pending sequence then times out.
        drv(0, 1, 2'd1, 0, 2'd0, 8'h00, 0);
        drv(0, 1, 2'd0, 0, 2'd0, 8'h00, 0);
        quiet(2);
        drv(0, 1, 2'd2, 0, 2'd0, 8'h00, 0);
        quiet(2);
        drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 1);
        quiet(24);
        chk("cur_sel_after_timeout", int'(cur_sel), 1);

        // Host held against a concurrent configuration request.
        drv(0, 1, 2'd3, 1, 2'd0, 8'h5A, 0);
        for (int i = 0; i < 6; i++) drv(0, 0, 2'd0, 1, 2'd0, 8'h5A, 0);
        drv(0, 0, 2'd0, 1, 2'd0, 8'h5A, 1);
        for (int i = 0; i < 3; i++) drv(0, 0, 2'd0, 1, 2'd0, 8'h5A, 0);

        // Host trying a divisor address.
        drv(0, 0, 2'd0, 1, 2'd3, 8'hFF, 0);
        chk("err_bus_addr", int'(brg_ioaddr), 1);
        drv(0, 0, 2'd0, 1, 2'd2, 8'h77, 0);
        quiet(2);

        // Reset landing in WR_HI.
        drv(0, 1, 2'd0, 0, 2'd0, 8'h00, 0);
        drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 0);
        drv(1, 0, 2'd0, 0, 2'd0, 8'h00, 0);
        chk_reset_outputs("midseq_reset");
        quiet(6);
        drv(0, 0, 2'd0, 0, 2'd0, 8'h00, 1);
        quiet(2);

        for (int i = 0; i < 4000; i++) begin
            drv($urandom_range(0, 399) == 0, $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 11) == 0);
        end
        quiet(4);
        @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL leftover_event cyc=%0d: DUT presented nothing, required addr=%0d data=%02h",
                     exp_q[0].cyc, exp_q[0].addr, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
